// File: rtl/mem_arbiter_32kb.sv
// rtl/mem_arbiter_32kb.sv - two-port round-robin arbiter and sequencer for the 32 KB banked memory
module mem_arbiter_32kb #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req0_i,
   input  logic              req1_i,
   input  logic              we0_i,
   input  logic              we1_i,
   input  logic [ADDR_W-1:0] addr0_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [DATA_W-1:0] wdata0_i,
   input  logic [DATA_W-1:0] wdata1_i,
   output logic              ack0_o,
   output logic              ack1_o,
   output logic [DATA_W-1:0] rdata0_o,
   output logic [DATA_W-1:0] rdata1_o,
   output logic              busy_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_data_in_o,
   output logic              mem_we_o,
   input  logic [DATA_W-1:0] mem_data_out_i
);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, READ = 2'd2, DONE = 2'd3} state_e;

   state_e            state_q, state_d;
   logic              grant_q, grant_d;          // port currently owning the memory
   logic              last_grant_q, last_grant_d;
   logic              ack0_q, ack0_d, ack1_q, ack1_d;
   logic              busy_q, busy_d;
   logic              mem_we_q, mem_we_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

   // State register and registered outputs; reset drops any in-flight access
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         grant_q       <= 1'b0;
         last_grant_q  <= 1'b1;
         ack0_q        <= 1'b0;
         ack1_q        <= 1'b0;
         busy_q        <= 1'b0;
         mem_we_q      <= 1'b0;
         rdata0_q      <= '0;
         rdata1_q      <= '0;
         mem_data_in_q <= '0;
         mem_addr_q    <= '0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         last_grant_q  <= last_grant_d;
         ack0_q        <= ack0_d;
         ack1_q        <= ack1_d;
         busy_q        <= busy_d;
         mem_we_q      <= mem_we_d;
         rdata0_q      <= rdata0_d;
         rdata1_q      <= rdata1_d;
         mem_data_in_q <= mem_data_in_d;
         mem_addr_q    <= mem_addr_d;
      end
   end

   // Next state: arbitrate in IDLE, writes skip the READ cycle
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (req0_i || req1_i) begin
               state_d = ISSUE;
               if (req0_i && req1_i) begin
                  grant_d = ~last_grant_q;
               end else begin
                  grant_d = req1_i;
               end
            end
         end
         ISSUE:   state_d = mem_we_q ? DONE : READ;
         READ:    state_d = DONE;
         default: begin
            state_d      = IDLE;
            last_grant_d = grant_q;
         end
      endcase
   end

   // Output next-values: latch the winner's command, capture read data, pulse ack into DONE
   always_comb begin
      mem_we_d      = 1'b0;
      mem_addr_d    = mem_addr_q;
      mem_data_in_d = mem_data_in_q;
      rdata0_d      = rdata0_q;
      rdata1_d      = rdata1_q;
      case (state_q)
         IDLE: begin
            if (state_d == ISSUE) begin
               if (grant_d) begin
                  mem_we_d      = we1_i;
                  mem_addr_d    = addr1_i;
                  mem_data_in_d = wdata1_i;
               end else begin
                  mem_we_d      = we0_i;
                  mem_addr_d    = addr0_i;
                  mem_data_in_d = wdata0_i;
               end
            end
         end
         READ: begin
            if (grant_q) begin
               rdata1_d = mem_data_out_i;
            end else begin
               rdata0_d = mem_data_out_i;
            end
         end
         default: ;
      endcase
      ack0_d = (state_d == DONE) && !grant_q;
      ack1_d = (state_d == DONE) && grant_q;
      busy_d = (state_d != IDLE);
   end

   assign ack0_o        = ack0_q;
   assign ack1_o        = ack1_q;
   assign rdata0_o      = rdata0_q;
   assign rdata1_o      = rdata1_q;
   assign busy_o        = busy_q;
   assign mem_we_o      = mem_we_q;
   assign mem_addr_o    = mem_addr_q;
   assign mem_data_in_o = mem_data_in_q;

endmodule

// File: tb/tb_mem_arbiter_32kb.sv
// tb/tb_mem_arbiter_32kb.sv - randomized self-checking bench for mem_arbiter_32kb
module tb_mem_arbiter_32kb;
   localparam int AW = 15;
   localparam int DW = 8;

   logic          clk, rst_n;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          ack0, ack1, busy, mem_we;
   logic [DW-1:0] rdata0, rdata1, mem_data_in, mem_dout;
   logic [AW-1:0] mem_addr;

   logic [DW-1:0] phys    [0:32767];
   logic [DW-1:0] ref_mem [0:32767];
   int            total, bad;
   bit            model_last;

   mem_arbiter_32kb #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
      .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
      .ack0_o(ack0), .ack1_o(ack1), .rdata0_o(rdata0), .rdata1_o(rdata1),
      .busy_o(busy), .mem_addr_o(mem_addr), .mem_data_in_o(mem_data_in),
      .mem_we_o(mem_we), .mem_data_out_i(mem_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      mem_dout <= phys[mem_addr];
      if (mem_we) phys[mem_addr] = mem_data_in;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int lat_of(input bit w);
      return w ? 2 : 3;
   endfunction

   task automatic drive(input int p, input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (p == 0) begin
         req0 = r; we0 = w; addr0 = a; wdata0 = d;
      end else begin
         req1 = r; we1 = w; addr1 = a; wdata1 = d;
      end
   endtask

   task automatic do_txn(input int p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit drop, output int lat, output logic [DW-1:0] rd,
                         output int wc, output bit oth);
      lat = -1; rd = '0; wc = 0; oth = 0;
      drive(p, 1'b1, w, a, d);
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); @(negedge clk);
         if (drop && c == 1) begin
            if (p == 0) req0 = 1'b0; else req1 = 1'b0;
         end
         if (mem_we) wc++;
         if ((p == 0) ? ack1 : ack0) oth = 1'b1;
         if ((p == 0) ? ack0 : ack1) begin
            lat = c;
            rd  = (p == 0) ? rdata0 : rdata1;
            break;
         end
      end
      drive(p, 1'b0, w, a, d);
      if (lat > 0) begin
         if (w) ref_mem[a] = d;
         model_last = p[0];
      end
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_reset();
      int lat, wc; logic [DW-1:0] rd; bit oth, quiet;
      repeat (2) @(negedge clk);
      total++;
      if ({ack0, ack1, busy, mem_we, rdata0, rdata1, mem_addr, mem_data_in} !== '0) begin
         bad++; $display("FAIL reset_outputs: got %h want 0", {ack0, ack1, busy, mem_we, rdata0, rdata1, mem_addr, mem_data_in});
      end
      rst_n = 1'b1; model_last = 1'b1;
      phys[15'h1234] = 8'h5A; ref_mem[15'h1234] = 8'h5A;
      @(negedge clk);
      do_txn(1, 1'b0, 15'h1234, 8'h00, 1'b0, lat, rd, wc, oth);
      total++;
      if (rd !== 8'h5A) begin bad++; $display("FAIL reset_preload_read: got %h want 5a", rd); end
      drive(0, 1'b1, 1'b1, 15'h2222, ~ref_mem[15'h2222]);
      @(posedge clk); @(negedge clk);
      total++;
      if (mem_we !== 1'b1) begin bad++; $display("FAIL reset_issue_we: got %b want 1", mem_we); end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({mem_we, busy, ack0} !== 3'b000) begin bad++; $display("FAIL async_reset: we/busy/ack=%b want 000", {mem_we, busy, ack0}); end
      total++;
      if ({rdata0, rdata1} !== '0) begin bad++; $display("FAIL reset_rdata_clear: got %h want 0", {rdata0, rdata1}); end
      drive(0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      rst_n = 1'b1; model_last = 1'b1;
      quiet = 1'b1;
      repeat (6) begin
         @(posedge clk); @(negedge clk);
         if (ack0 || ack1 || busy) quiet = 1'b0;
      end
      total++;
      if (quiet !== 1'b1) begin bad++; $display("FAIL reset_no_ack: activity seen after release"); end
      do_txn(0, 1'b0, 15'h2222, 8'h00, 1'b0, lat, rd, wc, oth);
      total++;
      if (rd !== ref_mem[15'h2222]) begin bad++; $display("FAIL reset_discarded_write: got %h want %h", rd, ref_mem[15'h2222]); end
   endtask

   task automatic test_single_port0();
      int lat, wc; logic [DW-1:0] rd; bit oth;
      do_txn(0, 1'b1, 15'h7C05, 8'hA5, 1'b0, lat, rd, wc, oth);
      total++;
      if (lat !== 2) begin bad++; $display("FAIL write_latency: got %0d want 2", lat); end
      total++;
      if (wc !== 1) begin bad++; $display("FAIL write_we_cycles: got %0d want 1", wc); end
      do_txn(0, 1'b0, 15'h7C05, 8'h00, 1'b0, lat, rd, wc, oth);
      total++;
      if (lat !== 3) begin bad++; $display("FAIL read_latency: got %0d want 3", lat); end
      total++;
      if (rd !== 8'hA5) begin bad++; $display("FAIL read_data: got %h want a5", rd); end
      total++;
      if (oth !== 1'b0 || wc !== 0) begin bad++; $display("FAIL read_side_effects: ack1=%b we_cycles=%0d want 0/0", oth, wc); end
      total++;
      if (ack0 !== 1'b0 || rdata0 !== 8'hA5) begin bad++; $display("FAIL rdata_hold: ack0=%b rdata0=%h want 0/a5", ack0, rdata0); end
   endtask

   task automatic test_bank_boundary();
      int lat, wc; logic [DW-1:0] rd; bit oth;
      do_txn(1, 1'b1, 15'h03FF, 8'h11, 1'b0, lat, rd, wc, oth);
      do_txn(1, 1'b1, 15'h0400, 8'h22, 1'b0, lat, rd, wc, oth);
      do_txn(1, 1'b0, 15'h03FF, 8'h00, 1'b0, lat, rd, wc, oth);
      total++;
      if (rd !== 8'h11 || lat !== 3) begin bad++; $display("FAIL bank_3ff: data=%h lat=%0d want 11/3", rd, lat); end
      do_txn(1, 1'b0, 15'h0400, 8'h00, 1'b0, lat, rd, wc, oth);
      total++;
      if (rd !== 8'h22 || lat !== 3) begin bad++; $display("FAIL bank_400: data=%h lat=%0d want 22/3", rd, lat); end
   endtask

   task automatic test_drop();
      int lat, wc; logic [DW-1:0] rd; bit oth; logic [AW-1:0] a;
      a = AW'($urandom);
      do_txn(0, 1'b0, a, 8'h00, 1'b1, lat, rd, wc, oth);
      total++;
      if (lat !== 3 || rd !== ref_mem[a]) begin bad++; $display("FAIL dropped_req: lat=%0d data=%h want 3/%h", lat, rd, ref_mem[a]); end
   endtask

   task automatic test_simultaneous();
      logic [AW-1:0] a0, a1; logic [DW-1:0] r0, r1;
      int c0, c1, win_c, lose_c; bit win;
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1; model_last = 1'b1;
      a0 = AW'($urandom); a1 = AW'($urandom);
      c0 = -1; c1 = -1; r0 = '0; r1 = '0;
      drive(0, 1'b1, 1'b0, a0, '0);
      drive(1, 1'b1, 1'b0, a1, '0);
      for (int c = 1; c <= 30 && (c0 < 0 || c1 < 0); c++) begin
         @(posedge clk); @(negedge clk);
         if (ack0) begin c0 = c; r0 = rdata0; req0 = 1'b0; end
         if (ack1) begin c1 = c; r1 = rdata1; req1 = 1'b0; end
      end
      win    = ~model_last;
      win_c  = lat_of(1'b0);
      lose_c = win_c + 1 + lat_of(1'b0);
      total++;
      if ((win ? c1 : c0) !== win_c) begin bad++; $display("FAIL tie_winner_ack: cycle=%0d want %0d", win ? c1 : c0, win_c); end
      total++;
      if ((win ? c0 : c1) !== lose_c) begin bad++; $display("FAIL tie_loser_ack: cycle=%0d want %0d", win ? c0 : c1, lose_c); end
      total++;
      if (r0 !== ref_mem[a0] || r1 !== ref_mem[a1]) begin
         bad++; $display("FAIL tie_read_data: got %h/%h want %h/%h", r0, r1, ref_mem[a0], ref_mem[a1]);
      end
      model_last = ~win;
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_fairness();
      bit pw[2]; logic [AW-1:0] pa[2]; logic [DW-1:0] pd[2]; logic [AW-1:0] pool[4];
      int n_ack[2]; int acks, prev, exp_c; bit pb, exp_p; logic [DW-1:0] got;
      for (int i = 0; i < 4; i++) pool[i] = AW'($urandom);
      n_ack[0] = 0; n_ack[1] = 0; acks = 0; prev = 0;
      for (int p = 0; p < 2; p++) begin
         pw[p] = 1'($urandom_range(0, 1)); pa[p] = pool[$urandom_range(0, 3)]; pd[p] = DW'($urandom);
         drive(p, 1'b1, pw[p], pa[p], pd[p]);
      end
      for (int c = 1; c <= 80 && acks < 8; c++) begin
         @(posedge clk); @(negedge clk);
         if (ack0 && ack1) begin
            total++; bad++; $display("FAIL fair_dual_ack: both acks at cycle %0d", c);
         end else if (ack0 || ack1) begin
            pb = ack1; exp_p = ~model_last;
            total++;
            if (pb !== exp_p) begin bad++; $display("FAIL fair_order: ack %0d went to port %0d want %0d", acks, pb, exp_p); end
            exp_c = prev + ((acks == 0) ? 0 : 1) + lat_of(pw[pb]);
            total++;
            if (c !== exp_c) begin bad++; $display("FAIL fair_spacing: ack %0d at cycle %0d want %0d", acks, c, exp_c); end
            if (pw[pb]) begin
               ref_mem[pa[pb]] = pd[pb];
            end else begin
               got = pb ? rdata1 : rdata0;
               total++;
               if (got !== ref_mem[pa[pb]]) begin bad++; $display("FAIL fair_read: port %0d got %h want %h", pb, got, ref_mem[pa[pb]]); end
            end
            model_last = pb; prev = c; acks++; n_ack[pb]++;
            pw[pb] = 1'($urandom_range(0, 1)); pa[pb] = pool[$urandom_range(0, 3)]; pd[pb] = DW'($urandom);
            drive(int'(pb), 1'b1, pw[pb], pa[pb], pd[pb]);
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      total++;
      if (n_ack[0] !== 4 || n_ack[1] !== 4) begin bad++; $display("FAIL fair_share: port0=%0d port1=%0d want 4/4", n_ack[0], n_ack[1]); end
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_back_to_back();
      bit w, prev_ack; logic [AW-1:0] a; logic [DW-1:0] d;
      int acks, prev, issue_c, exp_c;
      acks = 0; prev = 0; issue_c = 1; prev_ack = 1'b0;
      w = 1'($urandom_range(0, 1)); a = AW'($urandom); d = DW'($urandom);
      drive(1, 1'b1, w, a, d);
      for (int c = 1; c <= 60 && acks < 6; c++) begin
         @(posedge clk); @(negedge clk);
         total++;
         if (busy !== !prev_ack) begin bad++; $display("FAIL b2b_busy: cycle %0d got %b want %b", c, busy, !prev_ack); end
         total++;
         if (mem_we !== (c == issue_c && w)) begin bad++; $display("FAIL b2b_we: cycle %0d got %b want %b", c, mem_we, (c == issue_c && w)); end
         if (busy) begin
            total++;
            if (mem_addr !== a) begin bad++; $display("FAIL b2b_addr: cycle %0d got %h want %h", c, mem_addr, a); end
         end
         total++;
         if (ack0 !== 1'b0) begin bad++; $display("FAIL b2b_stray_ack0: cycle %0d got 1 want 0", c); end
         prev_ack = ack1;
         if (ack1) begin
            exp_c = prev + ((acks == 0) ? 0 : 1) + lat_of(w);
            total++;
            if (c !== exp_c) begin bad++; $display("FAIL b2b_ack_cycle: ack %0d at %0d want %0d", acks, c, exp_c); end
            if (w) begin
               ref_mem[a] = d;
            end else begin
               total++;
               if (rdata1 !== ref_mem[a]) begin bad++; $display("FAIL b2b_read: got %h want %h", rdata1, ref_mem[a]); end
            end
            model_last = 1'b1; acks++; prev = c; issue_c = c + 2;
            w = 1'($urandom_range(0, 1)); a = AW'($urandom); d = DW'($urandom);
            drive(1, 1'b1, w, a, d);
         end
      end
      req1 = 1'b0;
      total++;
      if (acks !== 6) begin bad++; $display("FAIL b2b_ack_count: got %0d want 6", acks); end
      @(posedge clk); @(negedge clk);
   endtask

   initial begin
      total = 0; bad = 0; model_last = 1'b1;
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      for (int i = 0; i < 32768; i++) begin
         phys[i]    = DW'($urandom);
         ref_mem[i] = phys[i];
      end
      test_reset();
      test_single_port0();
      test_bank_boundary();
      test_drop();
      test_simultaneous();
      test_fairness();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter_32kb.md
# mem_arbiter_32kb

Two-port round-robin arbiter and sequencer for the 32 KB byte-wide banked memory (32 banks of 1 KB, selected by addr[14:10]). It shares the single memory port between two requesters, such as a CPU and a loader/DMA. For each granted request it drives one memory access, handles the one-cycle synchronous read latency, and returns a single-cycle acknowledge with read data.

## Interface
Parameters:
- ADDR_W, 15, byte address width (32 KB)
- DATA_W, 8, data width

Ports:
- clk  in  1  single clock; all state changes on posedge
- rst_n  in  1  reset, asynchronous, active-low
- req0 / req1  in  1  access request, port 0 / port 1
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  byte address
- wdata0 / wdata1  in  DATA_W  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  DATA_W  read data, valid when ack is high, held until the next read on that port
- busy  out  1  high whenever state != IDLE
- mem_addr  out  ADDR_W  to memory addr
- mem_data_in  out  DATA_W  to memory data_in
- mem_we  out  1  to memory we
- mem_data_out  in  DATA_W  from memory data_out (registered inside the memory)

## Operation
- States: IDLE, ISSUE, READ, DONE. All outputs are registered.
- **IDLE**
  - With no request, stay in IDLE.
  - With exactly one request, grant that port.
  - With both requests, grant the port not granted last (round-robin).
  - On grant, latch the port's we, addr and wdata into mem_we, mem_addr and mem_data_in, then go to ISSUE.
- **ISSUE**
  - The memory samples mem_addr and mem_we at the end of this cycle.
  - Write: go to DONE and clear mem_we on the same edge.
  - Read: go to READ.
- **READ**
  - mem_data_out is valid in this cycle.
  - Capture it into the granted port's rdata register, then go to DONE.
- **DONE**
  - Assert ack of the granted port only.
  - Update last_grant to the granted port, then go to IDLE.
- mem_we is high only during ISSUE of a write; it is never high for two consecutive cycles.
- mem_addr and mem_data_in hold their last value while in IDLE.
- The arbiter does no range checking; all 2^15 addresses are legal.

Requester handshake:
- A requester holds req, we, addr and wdata stable from assertion until it sees ack.
- If req is still high in the IDLE cycle after ack, it is treated as a new transaction.
- Inputs of a port are ignored while the other port is granted.

## Timing
- Reset state: IDLE, with last_grant = 1 so port 0 wins the first tie.
- All outputs reset to 0: ack0, ack1, rdata0, rdata1, busy, mem_addr, mem_data_in, mem_we.
- Write latency: req sampled in IDLE at cycle T; ISSUE at T+1; ack at T+2. Minimum period 3 cycles per transaction.
- Read latency: ISSUE at T+1, READ at T+2, ack and rdata at T+3. Minimum period 4 cycles per transaction.
- Both requests asserted in the same IDLE cycle: exactly one grant, per round-robin; the loser is served next, with no starvation.
- Loser waiting: a port that keeps req high while the other is served is granted in the IDLE cycle immediately following the other port's DONE.
- Reset mid-operation: asynchronous return to IDLE.
  - mem_we and ack drop immediately.
  - The in-flight transaction is discarded; no ack is issued.
  - rdata registers clear.
- Request dropped before ack (protocol violation): the transaction still completes and ack pulses.

## Test plan
- **Reset:** assert rst_n = 0 mid-ISSUE of a write -> mem_we = 0 and busy = 0 asynchronously; no ack after release.
- **Single write then read, port 0:** write addr 0x7C05 = 0xA5 -> mem_we high exactly one cycle, ack0 at T+2. Then read 0x7C05 -> ack0 at T+3 with rdata0 = 0xA5, and ack1 stays 0.
- **Bank boundary:** write 0x03FF = 0x11 and 0x0400 = 0x22 from port 1 -> reads return 0x11 and 0x22 respectively (distinct banks).
- **Simultaneous requests after reset:** req0 and req1 both read -> port 0 acked first; port 1 granted in the next IDLE and acked 4 cycles later.
- **Fairness:** hold req0 and req1 continuously for 8 transactions -> grants strictly alternate 0,1,0,1,…; each port gets 4.
- **Back-to-back:** port 1 keeps req1 high after ack1 with a new address -> new ISSUE begins the cycle after IDLE; no lost or duplicated ack, and busy drops only in IDLE cycles.
